interface_spislave_ext: RTL
===========================

# interface_spislave_ext

Parametrised SPI slave that moves one fixed-length frame per chip-select window between an external SPI master and the FPGA. It generalises our SPI frame interface with selectable SPI mode (CPOL/CPHA), synchronous reset, strict frame-length checking, valid/error strobes, error counting and an optional CRC-8 frame check. It sits between the board SPI pins and the register/command decoder, which consumes `rx_data` on `rx_valid` and supplies `tx_data`.

## Interface
- `BUFFER_SIZE`, 64: frame length in bits; multiple of 8, minimum 40.
- `MSGID`, 32'h74697277: required value of the frame's top 32 bits.
- `TIMEOUT`, 4800000: clk cycles without a valid frame before `pkg_timeout` asserts.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `SPI_SCK`  in  1  asynchronous SPI clock.
- `SPI_SSEL`  in  1  asynchronous chip select, active low.
- `SPI_MOSI`  in  1  asynchronous master data.
- `SPI_MISO`  out  1  slave data, MSB first; reset 0.
- `tx_data`  in  BUFFER_SIZE  reply frame, captured at frame start.
- `rx_data`  out  BUFFER_SIZE  last accepted frame; reset 0.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates; reset 0.
- `frame_err`  out  1  one-cycle pulse on a rejected frame; reset 0.
- `err_count`  out  8  rejected frames, saturating at 255; reset 0.
- `busy`  out  1  high in SHIFT or CHECK; reset 0.
- `pkg_timeout`  out  1  high when no valid frame for TIMEOUT cycles; reset 0.

## Operation
- SCK, SSEL and MOSI each pass through a 3-flop shift register (2 sync, 1 edge-detect). Reset values: SSEL=1, SCK=CPOL, MOSI=0. MOSI is sampled from the stage aligned with SCK edge detection.
- Leading edge is the SCK rising edge when CPOL=0 and the falling edge when CPOL=1. The trailing edge is the opposite transition.
- `armed` flag: cleared by reset; set once synchronized SSEL is seen high. A frame can start only when `armed`=1, so no frame starts from an SSEL that was already low at reset.
- FSM:
  - IDLE: on SSEL falling edge with `armed`=1, load the TX shift register from `tx_data`, clear the bit counter, go to SHIFT.
  - SHIFT: on each sample edge, shift MOSI into the RX shift register LSB-first, pushing earlier bits toward the MSB. Increment the bit counter, saturating at BUFFER_SIZE+1. On SSEL rising edge go to CHECK.
  - CHECK (exactly 1 cycle): accept the frame if the bit count equals BUFFER_SIZE, `rx[BUFFER_SIZE-1 -: 32]` equals MSGID, and the CRC check passes when enabled.
    - Accept: copy RX to `rx_data`, pulse `rx_valid`, clear the timeout counter.
    - Reject: pulse `frame_err`, increment `err_count` (saturating); `rx_data` is unchanged.
    - Then go to IDLE.
- MISO is the MSB of the TX shift register while in SHIFT, and 0 otherwise.
  - CPHA=0: shift left on every trailing edge.
  - CPHA=1: shift left on every leading edge except the first of the frame.
  - Zeros fill from the right, so MISO reads 0 once all BUFFER_SIZE bits have been sent.
- Timeout counter: increments every cycle, saturating at TIMEOUT. `pkg_timeout` = (counter == TIMEOUT).

## Timing
- SCK frequency must be ≤ clk/8.
- Pin to internal edge detection takes 3 clk cycles.
- SSEL rising edge (synchronized) to `rx_valid`/`frame_err` is 1 clk cycle (the CHECK cycle). `rx_data` is valid in the same cycle as `rx_valid`.
- `pkg_timeout` asserts exactly TIMEOUT cycles after the last accept; it deasserts the cycle after an accept.
- If an SSEL rising edge and an SCK edge are detected in the same cycle, the SSEL event wins and the SCK edge is ignored.
- Changes to `tx_data` during SHIFT have no effect on the frame in progress.
- `rst` asserted mid-frame: all outputs return to reset values, the frame is discarded, and the FSM goes to IDLE with `armed`=0.
- Bit count < BUFFER_SIZE (short frame) or > BUFFER_SIZE (long frame): rejected.

## Configuration
- `SPISLAVE_CRC8_EN` defined:
  - The last 8 frame bits carry a CRC-8 (polynomial 0x07, init 0x00, MSB first) computed over the first BUFFER_SIZE-8 bits.
  - A CRC mismatch on receive causes rejection.
  - On transmit, `tx_data[7:0]` is replaced at load time by the CRC of `tx_data[BUFFER_SIZE-1:8]`.
  - `rx_data` includes the received CRC byte.
- Not defined: no CRC logic; all BUFFER_SIZE bits pass through unchanged.

## Test plan
- Mode 0, BUFFER_SIZE=64: send 64'h74697277_DEADBEEF with `tx_data`=64'h0123456789ABCDEF -> `rx_valid` pulses once, `rx_data`=64'h74697277DEADBEEF, MISO stream = 64'h0123456789ABCDEF.
- Repeat the same frame in modes 1, 2 and 3 -> identical `rx_data` and MISO stream in every mode.
- Send 63 bits, then 65 bits, then a header of 32'h74697278 -> three `frame_err` pulses, `err_count`=3, `rx_data` unchanged.
- TIMEOUT=100: one valid frame, then idle -> `pkg_timeout` rises exactly 100 cycles after `rx_valid`; the next valid frame clears it one cycle later.
- Assert `rst` at bit 30 with SSEL held low, then complete the frame -> no `rx_valid` and no `frame_err`. Next full SSEL cycle is accepted.
- With `SPISLAVE_CRC8_EN` defined: correct CRC byte -> accept; flip one payload bit -> `frame_err`. MISO last byte = CRC-8 of `tx_data[63:8]`.

Source files
------------

// File: rtl/interface_spislave_ext.sv
`timescale 1ns/1ps
// interface_spislave_ext
//
// SPI slave that moves one fixed-length frame per chip-select window between
// an external SPI master and the register/command decoder. All SPI pins are
// oversampled on clk (SCK must run at clk/8 or slower).
//
// Parameters
//   BUFFER_SIZE : frame length in bits (multiple of 8, >= 40)
//   MSGID       : required value of the top 32 frame bits
//   TIMEOUT     : clk cycles without an accepted frame before pkg_timeout
//   CPOL        : SCK idle level
//   CPHA        : 0 = sample on leading edge, 1 = sample on trailing edge
//
// Optional feature macro: SPISLAVE_CRC8_EN
//   Defined   : last frame byte is a CRC-8 (poly 0x07, init 0) over the
//               preceding bits; checked on receive, inserted on transmit.
//   Undefined : all frame bits pass through unchanged.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   SPI_SCK/SSEL/MOSI   : asynchronous SPI pins (SSEL active low)
//   SPI_MISO            : slave data, MSB first, 0 outside a frame
//   tx_data             : reply frame, captured when the frame starts
//   rx_data, rx_valid   : last accepted frame + one-cycle update strobe
//   frame_err           : one-cycle strobe on a rejected frame
//   err_count           : saturating count of rejected frames
//   busy                : frame in progress (SHIFT or CHECK)
//   pkg_timeout         : no accepted frame for TIMEOUT cycles
module interface_spislave_ext #(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int          TIMEOUT     = 4800000,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SPI_SCK,
  input  logic                   SPI_SSEL,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic [7:0]             err_count,
  output logic                   busy,
  output logic                   pkg_timeout
);

  localparam int BCW = $clog2(BUFFER_SIZE + 2);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(BUFFER_SIZE);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(BUFFER_SIZE + 1);
  localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Pin synchronizers: [0],[1] synchronize, [2] holds the previous value
  // for edge detection.
  logic [2:0] sck_r, ssel_r, mosi_r;
  // Cycles since reset, saturating at 3; the SSEL chain only holds real
  // pin samples once it has been flushed of its reset values.
  logic [1:0] fill;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_r  <= {3{CPOL}};
      ssel_r <= 3'b111;
      mosi_r <= 3'b000;
      fill   <= 2'd0;
      armed  <= 1'b0;
    end else begin
      sck_r  <= {sck_r[1:0], SPI_SCK};
      ssel_r <= {ssel_r[1:0], SPI_SSEL};
      mosi_r <= {mosi_r[1:0], SPI_MOSI};
      if (fill != 2'd3) fill <= fill + 2'd1;
      // Arm only on a genuine high SSEL, so an SSEL already held low across
      // reset can never masquerade as a frame start.
      if (fill == 2'd3 && ssel_r[1]) armed <= 1'b1;
    end
  end

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ssel_fall, ssel_rise, mosi_bit;

  assign sck_rise    = sck_r[1] & ~sck_r[2];
  assign sck_fall    = ~sck_r[1] & sck_r[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ssel_fall   = ~ssel_r[1] & ssel_r[2];
  assign ssel_rise   = ssel_r[1] & ~ssel_r[2];
  // MOSI as it stood alongside the pre-edge SCK level in stage [2].
  assign mosi_bit    = mosi_r[2];

  // Frame datapath
  state_t                 state, state_nx;
  logic [BUFFER_SIZE-1:0] tx_sr, rx_sr, tx_load;
  logic [BCW-1:0]         bit_cnt;
  logic [TCW-1:0]         tmo_cnt;
  logic                   first_lead;
  logic                   load_tx, sample, tx_shift, crc_ok, frame_ok;

`ifdef SPISLAVE_CRC8_EN
  function automatic logic [7:0] crc8(input logic [BUFFER_SIZE-9:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = BUFFER_SIZE - 9; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  assign tx_load = {tx_data[BUFFER_SIZE-1:8], crc8(tx_data[BUFFER_SIZE-1:8])};
  assign crc_ok  = (crc8(rx_sr[BUFFER_SIZE-1:8]) == rx_sr[7:0]);
`else
  assign tx_load = tx_data;
  assign crc_ok  = 1'b1;
`endif

  assign frame_ok = (bit_cnt == BC_FULL) &&
                    (rx_sr[BUFFER_SIZE-1 -: 32] == MSGID) && crc_ok;

  always_comb begin
    state_nx = state;
    load_tx  = 1'b0;
    sample   = 1'b0;
    tx_shift = 1'b0;
    case (state)
      IDLE: begin
        if (ssel_fall && armed) begin
          load_tx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        // SSEL release wins over a coincident SCK edge.
        if (ssel_rise) begin
          state_nx = CHECK;
        end else begin
          sample   = sample_edge;
          // In CPHA=1 the first leading edge launches bit 0, which is
          // already on MISO, so it must not advance the register.
          tx_shift = shift_edge && !(CPHA && first_lead);
        end
      end
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      first_lead <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
      tmo_cnt    <= '0;
    end else begin
      state     <= state_nx;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (load_tx) begin
        tx_sr      <= tx_load;
        rx_sr      <= '0;
        bit_cnt    <= '0;
        first_lead <= 1'b1;
      end else begin
        if (tx_shift) tx_sr <= {tx_sr[BUFFER_SIZE-2:0], 1'b0};
        if (state == SHIFT && lead_edge) first_lead <= 1'b0;
        if (sample) begin
          rx_sr <= {rx_sr[BUFFER_SIZE-2:0], mosi_bit};
          // Saturate one past full so long frames stay distinguishable.
          if (bit_cnt != BC_MAX) bit_cnt <= bit_cnt + BCW'(1);
        end
      end

      if (state == CHECK) begin
        if (frame_ok) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end

      if (state == CHECK && frame_ok) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)    tmo_cnt <= tmo_cnt + TCW'(1);
    end
  end

  assign SPI_MISO    = (state == SHIFT) && tx_sr[BUFFER_SIZE-1];
  assign busy        = (state != IDLE);
  assign pkg_timeout = (tmo_cnt == TMO_MAX);

endmodule
